// File: rtl/mem_fairness_monitor.sv
// Fairness monitor for N memory request/grant channels and the core irq line.
// Every rule is reported as a sticky violation flag; any_viol ORs them all.
module mem_fairness_monitor #(
    parameter int NCH         = 2,
    parameter int CNT_W       = 5,
    parameter int MAX_DELAY   = 5,
    parameter int ERR_MODE    = 0,
    parameter int ERR_WINDOW  = 16,
    parameter int IRQ_MODE    = 0,
    parameter int IRQ_MIN_GAP = 8
) (
    input  logic               g_clk,
    input  logic               g_resetn,
    input  logic [NCH-1:0]     req,
    input  logic [NCH-1:0]     gnt,
    input  logic [NCH-1:0]     err,
    input  logic               irq,
    input  logic               clr,
    output logic [NCH-1:0]     delay_viol,
    output logic [NCH-1:0]     proto_viol,
    output logic [NCH-1:0]     err_viol,
    output logic               irq_viol,
    output logic [NCH*CNT_W-1:0] max_wait,
    output logic               any_viol
);

    localparam int EG_W = $clog2(ERR_WINDOW + 1);
    localparam int IG_W = $clog2(IRQ_MIN_GAP + 1);
    localparam logic [CNT_W-1:0] W_SAT  = '1;
    localparam logic [CNT_W-1:0] W_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] D_THR  = CNT_W'(MAX_DELAY - 1);
    localparam logic [EG_W-1:0]  EG_MAX = EG_W'(ERR_WINDOW);
    localparam logic [EG_W-1:0]  EG_ONE = EG_W'(1);
    localparam logic [IG_W-1:0]  IG_MAX = IG_W'(IRQ_MIN_GAP);
    localparam logic [IG_W-1:0]  IG_ONE = IG_W'(1);

    logic [CNT_W-1:0] w      [NCH];
    logic [CNT_W-1:0] w_nxt  [NCH];
    logic [CNT_W-1:0] mw     [NCH];
    logic [EG_W-1:0]  eg     [NCH];
    logic [EG_W-1:0]  eg_nxt [NCH];
    logic [NCH-1:0]   pend;
    logic [NCH-1:0]   rsp;
    logic [NCH-1:0]   stall;
    logic [NCH-1:0]   d_set;
    logic [NCH-1:0]   p_set;
    logic [NCH-1:0]   e_smp;
    logic [NCH-1:0]   e_set;
    logic [IG_W-1:0]  ig;
    logic             irq_q;
    logic             rise;
    logic             i_set;

    always_comb begin
        stall = req & ~gnt;
        d_set = '0;
        p_set = '0;
        e_smp = rsp & err;
        e_set = '0;
        for (int i = 0; i < NCH; i++) begin
            w_nxt[i] = '0;
            if (stall[i])
                w_nxt[i] = (w[i] == W_SAT) ? w[i] : w[i] + W_ONE;
            d_set[i] = stall[i] && (w[i] == D_THR);
            p_set[i] = pend[i] && !req[i];
            e_set[i] = e_smp[i] && ((ERR_MODE == 0) || (eg[i] < EG_MAX));
            if (e_smp[i])
                eg_nxt[i] = '0;
            else
                eg_nxt[i] = (eg[i] == EG_MAX) ? eg[i] : eg[i] + EG_ONE;
        end
        rise  = irq && !irq_q;
        i_set = (IRQ_MODE == 0) ? irq : (rise && (ig < IG_MAX));
    end

    // A withdrawn request is consumed by the violation, so pending tracks
    // only the immediately preceding stalled cycle.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int i = 0; i < NCH; i++) begin
                w[i]  <= '0;
                mw[i] <= '0;
                eg[i] <= EG_MAX;
            end
            pend       <= '0;
            rsp        <= '0;
            delay_viol <= '0;
            proto_viol <= '0;
            err_viol   <= '0;
            irq_viol   <= 1'b0;
            irq_q      <= 1'b0;
            ig         <= IG_MAX;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                w[i]  <= w_nxt[i];
                eg[i] <= eg_nxt[i];
                if (clr)
                    mw[i] <= '0;
                else if (w_nxt[i] > mw[i])
                    mw[i] <= w_nxt[i];
            end
            pend       <= stall;
            rsp        <= req & gnt;
            delay_viol <= (delay_viol & ~{NCH{clr}}) | d_set;
            proto_viol <= (proto_viol & ~{NCH{clr}}) | p_set;
            err_viol   <= (err_viol & ~{NCH{clr}}) | e_set;
            irq_viol   <= (irq_viol & !clr) | i_set;
            irq_q      <= irq;
            if (rise)
                ig <= '0;
            else if (ig != IG_MAX)
                ig <= ig + IG_ONE;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_mw
        assign max_wait[i*CNT_W +: CNT_W] = mw[i];
    end

    assign any_viol = |{delay_viol, proto_viol, err_viol, irq_viol};

endmodule
